// File: rtl/mips_cpu_pkg.sv
// Shared types and defaults for the multi-cycle MIPS control sequencer.
// Imported by the sequencer top and its mul/div busy timer.
package mips_cpu_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      EXEC   = 3'd1,
      MEM    = 3'd2,
      MDWAIT = 3'd3,
      HALT   = 3'd4
   } seq_state_t;

   localparam logic [31:0] RESET_VECTOR_DEFAULT  = 32'hBFC0_0000;
   localparam logic [31:0] HALT_ADDR_DEFAULT     = 32'h0000_0000;
   localparam int unsigned MULDIV_CYCLES_DEFAULT = 32;

   // Sequential fall-through address; wraps modulo 2^32.
   function automatic logic [31:0] seq_next_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/mips_cpu_sequencer_if.sv
// Bus-side signals of the sequencer: instruction/data address source, strobes and stall.
// A read or write is held (same strobes, same address) for every cycle waitrequest is high; it completes on the first cycle its strobe is high and waitrequest is low.
interface mips_cpu_sequencer_if;

   logic [31:0] pc;
   logic        addr_sel;
   logic        mem_read;
   logic        mem_write;
   logic        ir_load;
   logic        waitrequest;

   modport master (
      output pc,
      output addr_sel,
      output mem_read,
      output mem_write,
      output ir_load,
      input  waitrequest
   );

   modport slave (
      input  pc,
      input  addr_sel,
      input  mem_read,
      input  mem_write,
      input  ir_load,
      output waitrequest
   );

endinterface

// File: rtl/mips_cpu_muldiv_timer.sv
// Busy timer for the multi-cycle MULT/DIV unit: loaded on each issue, counts down to zero.
// busy_o stays high while HI/LO are not yet valid.
module mips_cpu_muldiv_timer #(
   parameter int unsigned CYCLES = 32
) (
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   output logic busy_o
);

   localparam int CW = $clog2(CYCLES + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // A re-issue while busy restarts the count from the top.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CW'(CYCLES);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/mips_cpu_sequencer.sv
// Multi-cycle control sequencer: owns the PC, steps FETCH/EXEC/MEM, stalls on the bus and on mul/div,
// implements the branch delay slot and halts when a jump lands on HALT_ADDR.
module mips_cpu_sequencer
   import mips_cpu_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR  = RESET_VECTOR_DEFAULT,
   parameter logic [31:0] HALT_ADDR     = HALT_ADDR_DEFAULT,
   parameter int unsigned MULDIV_CYCLES = MULDIV_CYCLES_DEFAULT
) (
   input  logic                        clk,
   input  logic                        reset,
   mips_cpu_sequencer_if.master        bus,
   input  logic                        is_load,
   input  logic                        is_store,
   input  logic                        is_muldiv,
   input  logic                        is_hilo_rd,
   input  logic                        branch_taken,
   input  logic [31:0]                 branch_target,
   output logic                        regwrite_en,
   output logic                        muldiv_start,
   output logic                        active,
   output logic [2:0]                  state
);

   seq_state_t  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        dly_pend_q, dly_pend_d;
   logic [31:0] dly_tgt_q, dly_tgt_d;
   logic        active_q, active_d;

   logic        md_busy;
   logic        commit;
   logic        addr_sel_s;
   logic        mem_read_s;
   logic        mem_write_s;
   logic        ir_load_s;

   mips_cpu_muldiv_timer #(
      .CYCLES (MULDIV_CYCLES)
   ) u_muldiv_timer (
      .clk    (clk),
      .reset  (reset),
      .load_i (muldiv_start),
      .busy_o (md_busy)
   );

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      dly_pend_d   = dly_pend_q;
      dly_tgt_d    = dly_tgt_q;
      active_d     = active_q;
      commit       = 1'b0;
      addr_sel_s   = 1'b0;
      mem_read_s   = 1'b0;
      mem_write_s  = 1'b0;
      ir_load_s    = 1'b0;
      regwrite_en  = 1'b0;
      muldiv_start = 1'b0;

      case (state_q)
         FETCH: begin
            mem_read_s = 1'b1;
            if (!bus.waitrequest) begin
               ir_load_s = 1'b1;
               state_d   = EXEC;
            end
         end
         EXEC: begin
            if (is_load || is_store) begin
               state_d = MEM;
            end else if (is_hilo_rd && md_busy) begin
               state_d = MDWAIT;
            end else if (is_muldiv) begin
               muldiv_start = 1'b1;
               commit       = 1'b1;
            end else begin
               regwrite_en = 1'b1;
               commit      = 1'b1;
            end
         end
         MEM: begin
            addr_sel_s  = 1'b1;
            mem_read_s  = is_load;
            mem_write_s = is_store;
            if (!bus.waitrequest) begin
               regwrite_en = is_load;
               commit      = 1'b1;
            end
         end
         MDWAIT: begin
            if (!md_busy) begin
               regwrite_en = 1'b1;
               commit      = 1'b1;
            end
         end
         HALT: begin
         end
         default: begin
            state_d = FETCH;
         end
      endcase

      // Commit: a pending delay-slot target is consumed here; otherwise a taken branch arms one.
      if (commit) begin
         state_d = FETCH;
         if (dly_pend_q) begin
            pc_d       = dly_tgt_q;
            dly_pend_d = 1'b0;
            if (dly_tgt_q == HALT_ADDR) begin
               state_d  = HALT;
               active_d = 1'b0;
            end
         end else begin
            pc_d = seq_next_pc(pc_q);
            if (branch_taken) begin
               dly_pend_d = 1'b1;
               dly_tgt_d  = branch_target;
            end
         end
      end

      // Reset abandons any transaction in the very cycle it is asserted.
      if (reset) begin
         addr_sel_s   = 1'b0;
         mem_read_s   = 1'b0;
         mem_write_s  = 1'b0;
         ir_load_s    = 1'b0;
         regwrite_en  = 1'b0;
         muldiv_start = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FETCH;
         pc_q       <= RESET_VECTOR;
         dly_pend_q <= 1'b0;
         dly_tgt_q  <= '0;
         active_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         dly_pend_q <= dly_pend_d;
         dly_tgt_q  <= dly_tgt_d;
         active_q   <= active_d;
      end
   end

   assign bus.pc        = pc_q;
   assign bus.addr_sel  = addr_sel_s;
   assign bus.mem_read  = mem_read_s;
   assign bus.mem_write = mem_write_s;
   assign bus.ir_load   = ir_load_s;
   assign active        = active_q;
   assign state         = state_q;

endmodule

// File: tb/tb_mips_cpu_sequencer.sv
// Bench for mips_cpu_sequencer: directed scenarios plus a random instruction stream,
// checked cycle by cycle against a timing/architectural model of the sequencer.
module tb_mips_cpu_sequencer;
   import mips_cpu_pkg::*;

   localparam logic [31:0] RV  = 32'hBFC0_0000;
   localparam int          MDC = 32;

   localparam int K_ALU   = 0;
   localparam int K_LOAD  = 1;
   localparam int K_STORE = 2;
   localparam int K_MD    = 3;
   localparam int K_HILO  = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        is_load, is_store, is_muldiv, is_hilo_rd, branch_taken;
   logic [31:0] branch_target;
   logic        regwrite_en, muldiv_start, active;
   logic [2:0]  state;

   mips_cpu_sequencer_if bus ();

   mips_cpu_sequencer #(
      .RESET_VECTOR  (RV),
      .HALT_ADDR     (32'h0),
      .MULDIV_CYCLES (MDC)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .is_load       (is_load),
      .is_store      (is_store),
      .is_muldiv     (is_muldiv),
      .is_hilo_rd    (is_hilo_rd),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .regwrite_en   (regwrite_en),
      .muldiv_start  (muldiv_start),
      .active        (active),
      .state         (state)
   );

   always #5 clk = ~clk;

   int cycle_no = 0;
   always @(posedge clk) cycle_no <= cycle_no + 1;

   int checks = 0;
   int errors = 0;

   // Architectural model: PC, delay slot, halt flag, and the absolute cycle at which HI/LO become valid.
   logic [31:0] m_pc;
   logic        m_dly;
   logic [31:0] m_tgt;
   logic        m_halted;
   int          m_md_ready;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] strobes();
      return 32'({bus.mem_read, bus.mem_write, bus.addr_sel, bus.ir_load, regwrite_en, muldiv_start});
   endfunction

   task automatic set_decode(input int kind, input bit taken, input logic [31:0] tgt);
      is_load       = (kind == K_LOAD);
      is_store      = (kind == K_STORE);
      is_muldiv     = (kind == K_MD);
      is_hilo_rd    = (kind == K_HILO);
      branch_taken  = taken;
      branch_target = tgt;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.waitrequest = 1'b0;
      set_decode(K_ALU, 1'b0, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      check("strobes_in_reset", strobes(), 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      m_pc = RV; m_dly = 1'b0; m_tgt = 32'h0; m_halted = 1'b0; m_md_ready = 0;
      check("reset_state", 32'(state), 32'(FETCH));
      check("reset_pc", bus.pc, RV);
      check("reset_active", 32'(active), 32'h1);
   endtask

   // Runs one instruction from its first FETCH cycle through commit; called at posedge+1.
   task automatic run_instr(input int kind, input int fw, input int mw, input bit taken,
                            input logic [31:0] tgt);
      int start_abs, exec_c, commit_c, mdrel;
      bit ldst;
      logic [31:0] exp_v;
      logic rd, wr, asel, irl, rw, st;
      ldst      = (kind == K_LOAD) || (kind == K_STORE);
      start_abs = cycle_no;
      exec_c    = fw + 1;
      commit_c  = exec_c;
      if (ldst) commit_c = exec_c + 1 + mw;
      if (kind == K_HILO) begin
         mdrel = m_md_ready - start_abs;
         if (mdrel > exec_c) commit_c = mdrel;
      end
      set_decode(kind, taken, tgt);
      for (int c = 0; c <= commit_c; c++) begin
         bus.waitrequest = (c < fw) || (ldst && c > exec_c && c < exec_c + 1 + mw);
         @(negedge clk);
         rd   = (c <= fw) || (kind == K_LOAD && c > exec_c);
         wr   = (kind == K_STORE) && (c > exec_c);
         asel = ldst && (c > exec_c);
         irl  = (c == fw);
         rw   = (c == commit_c) && (kind != K_STORE) && (kind != K_MD);
         st   = (kind == K_MD) && (c == exec_c);
         exp_v = 32'({rd, wr, asel, irl, rw, st});
         check($sformatf("strobes k%0d c%0d", kind, c), strobes(), exp_v);
         if (c == 0) check("fetch_pc", bus.pc, m_pc);
         @(posedge clk); #1;
      end
      bus.waitrequest = 1'b0;
      if (kind == K_MD) m_md_ready = start_abs + exec_c + MDC + 1;
      if (m_dly) begin
         m_pc  = m_tgt;
         m_dly = 1'b0;
         if (m_tgt == 32'h0) m_halted = 1'b1;
      end else begin
         m_pc = m_pc + 32'd4;
         if (taken) begin
            m_dly = 1'b1;
            m_tgt = tgt;
         end
      end
      check("state_after", 32'(state), m_halted ? 32'(HALT) : 32'(FETCH));
      check("pc_after", bus.pc, m_pc);
      check("active_after", 32'(active), m_halted ? 32'h0 : 32'h1);
   endtask

   initial begin
      int kind, fw, mw;
      bit taken;
      logic [31:0] tgt;

      // 1. ADDU, no waits
      do_reset();
      run_instr(K_ALU, 0, 0, 1'b0, 32'h0);

      // 2. LW with 3 fetch waits and 2 mem waits
      do_reset();
      run_instr(K_LOAD, 3, 2, 1'b0, 32'h0);
      run_instr(K_STORE, 1, 1, 1'b0, 32'h0);

      // 3. Taken branch, delay slot holding a (ignored) taken branch, then the target
      do_reset();
      run_instr(K_ALU, 0, 0, 1'b1, 32'hBFC0_0100);
      run_instr(K_ALU, 0, 0, 1'b1, 32'hBFC0_0200);
      run_instr(K_ALU, 0, 0, 1'b0, 32'h0);

      // 5. MULT then MFLO, then a re-issue that restarts the busy count
      run_instr(K_MD, 0, 0, 1'b0, 32'h0);
      run_instr(K_HILO, 0, 0, 1'b0, 32'h0);
      run_instr(K_MD, 1, 0, 1'b0, 32'h0);
      run_instr(K_ALU, 2, 0, 1'b0, 32'h0);
      run_instr(K_MD, 0, 0, 1'b0, 32'h0);
      run_instr(K_HILO, 1, 0, 1'b0, 32'h0);

      // Random instruction stream with random stalls and branches
      for (int i = 0; i < 60; i++) begin
         kind  = $urandom_range(0, 4);
         fw    = $urandom_range(0, 3);
         mw    = $urandom_range(0, 3);
         taken = ($urandom_range(0, 3) == 0);
         tgt   = RV + {22'd0, 8'($urandom_range(1, 255)), 2'b00};
         run_instr(kind, fw, mw, taken, tgt);
      end

      // 4. JR to 0 with ADDU in the delay slot, then HALT holds for 20 cycles
      do_reset();
      run_instr(K_ALU, 0, 0, 1'b1, 32'h0);
      run_instr(K_ALU, 1, 0, 1'b0, 32'h0);
      for (int c = 0; c < 20; c++) begin
         bus.waitrequest = 1'($urandom_range(0, 1));
         set_decode($urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom);
         @(negedge clk);
         check($sformatf("halt_strobes c%0d", c), strobes(), 32'h0);
         check($sformatf("halt_state c%0d", c), 32'(state), 32'(HALT));
         check($sformatf("halt_pc c%0d", c), bus.pc, 32'h0);
         @(posedge clk); #1;
      end

      // 6. Reset while a store is stalled in MEM
      do_reset();
      run_instr(K_ALU, 0, 0, 1'b0, 32'h0);
      set_decode(K_STORE, 1'b0, 32'h0);
      bus.waitrequest = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.waitrequest = 1'b1;
      @(negedge clk);
      check("mem_write_before_reset", 32'(bus.mem_write), 32'h1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("strobes_reset_mid_mem", strobes(), 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      bus.waitrequest = 1'b0;
      check("state_after_mid_reset", 32'(state), 32'(FETCH));
      check("pc_after_mid_reset", bus.pc, RV);
      @(negedge clk);
      check("fetch_after_mid_reset", strobes(), 32'h24);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
